// File: rtl/cordic_pkg.sv
// cordic_pkg: shared types and constants for the sequential CORDIC rotator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cordic_pkg;

  localparam int DEF_WIDTH      = 32;
  localparam int DEF_ITERATIONS = 31;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROTATE = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Top two bits of the input angle select the quadrant.
  localparam logic [1:0] QUAD_0 = 2'b00;  // [0, 90) deg
  localparam logic [1:0] QUAD_1 = 2'b01;  // [90, 180) deg
  localparam logic [1:0] QUAD_2 = 2'b10;  // [-180, -90) deg
  localparam logic [1:0] QUAD_3 = 2'b11;  // [-90, 0) deg

endpackage

// File: rtl/cordic_atan_rom.sv
// cordic_atan_rom: arctan(2^-i) table, full scale 2^WIDTH = 360 deg.
// Latency: combinational, index -> angle in the same cycle.
// Backpressure: none; pure lookup.
// Ports: index (micro-rotation number), angle (signed WIDTH-bit phase step).
module cordic_atan_rom #(
  parameter int WIDTH      = 32,
  parameter int ITERATIONS = 31,
  localparam int IDX_W     = $clog2(ITERATIONS)
) (
  input  logic [IDX_W-1:0]        index,
  output logic signed [WIDTH-1:0] angle
);

  logic [31:0] idx32;
  logic [31:0] a32;   // round(atan(2^-i) * 2^32 / (2*pi))

  assign idx32 = 32'(index);

  always_comb begin
    a32 = '0;
    case (idx32)
      32'd0:  a32 = 32'h20000000;
      32'd1:  a32 = 32'h12E4051E;
      32'd2:  a32 = 32'h09FB385B;
      32'd3:  a32 = 32'h051111D4;
      32'd4:  a32 = 32'h028B0D43;
      32'd5:  a32 = 32'h0145D7E1;
      32'd6:  a32 = 32'h00A2F61E;
      32'd7:  a32 = 32'h00517C55;
      32'd8:  a32 = 32'h0028BE53;
      32'd9:  a32 = 32'h00145F2F;
      32'd10: a32 = 32'h000A2F98;
      32'd11: a32 = 32'h000517CC;
      32'd12: a32 = 32'h00028BE6;
      32'd13: a32 = 32'h000145F3;
      32'd14: a32 = 32'h0000A2FA;
      32'd15: a32 = 32'h0000517D;
      32'd16: a32 = 32'h000028BE;
      32'd17: a32 = 32'h0000145F;
      32'd18: a32 = 32'h00000A30;
      32'd19: a32 = 32'h00000518;
      32'd20: a32 = 32'h0000028C;
      32'd21: a32 = 32'h00000146;
      32'd22: a32 = 32'h000000A3;
      32'd23: a32 = 32'h00000051;
      32'd24: a32 = 32'h00000029;
      32'd25: a32 = 32'h00000014;
      32'd26: a32 = 32'h0000000A;
      32'd27: a32 = 32'h00000005;
      32'd28: a32 = 32'h00000003;
      32'd29: a32 = 32'h00000001;
      32'd30: a32 = 32'h00000001;
      default: a32 = '0;
    endcase
  end

  // The table is held at 32-bit scale and rescaled to the datapath width.
  generate
    if (WIDTH == 32) begin : g_eq
      assign angle = a32;
    end else if (WIDTH > 32) begin : g_wide
      assign angle = {a32, {(WIDTH-32){1'b0}}};
    end else begin : g_narrow
      logic [31:0] rnd;
      assign rnd   = a32 + (32'd1 << (31 - WIDTH));
      assign angle = rnd[31 -: WIDTH];
    end
  endgenerate

endmodule

// File: rtl/cordic_seq.sv
// cordic_seq: iterative CORDIC vector rotator, one micro-rotation per cycle.
// Latency: out_valid rises ITERATIONS edges after accept, counting the accepting edge.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE.
// Ports: in_valid/in_ready + x_in/y_in/z_in operand; out_valid/out_ready +
//        x_out/y_out/z_out result registers; busy = not IDLE.
module cordic_seq
  import cordic_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int ITERATIONS = DEF_ITERATIONS
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] x_in,
  input  logic signed [WIDTH-1:0] y_in,
  input  logic signed [WIDTH-1:0] z_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] x_out,
  output logic signed [WIDTH-1:0] y_out,
  output logic signed [WIDTH-1:0] z_out,
  output logic                    busy
);

  localparam int IDX_W = $clog2(ITERATIONS);

  state_t                  state, state_nxt;
  logic [IDX_W-1:0]        iter;
  logic signed [WIDTH-1:0] x_r, y_r, z_r;
  logic signed [WIDTH-1:0] x_ld, y_ld, z_ld;
  logic signed [WIDTH-1:0] x_rot, y_rot, z_rot;
  logic signed [WIDTH-1:0] x_sh, y_sh;
  logic signed [WIDTH-1:0] atan_i;
  logic                    last_iter;
  logic                    z_neg;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign last_iter = (iter == IDX_W'(ITERATIONS - 2));

  cordic_atan_rom #(
    .WIDTH      (WIDTH),
    .ITERATIONS (ITERATIONS)
  ) u_atan (
    .index (iter),
    .angle (atan_i)
  );

  // Pre-rotate by +/-90 deg so the residual angle lies within the
  // +/-99.9 deg convergence range of the micro-rotation sequence.
  always_comb begin
    x_ld = x_in;
    y_ld = y_in;
    z_ld = z_in;
    case (z_in[WIDTH-1 -: 2])
      QUAD_1: begin
        x_ld = -y_in;
        y_ld = x_in;
        z_ld = {2'b00, z_in[WIDTH-3:0]};
      end
      QUAD_2: begin
        x_ld = y_in;
        y_ld = -x_in;
        z_ld = {2'b11, z_in[WIDTH-3:0]};
      end
      default: ;
    endcase
  end

  // Single shared add/sub set; direction follows the sign of the residual angle.
  assign x_sh  = x_r >>> iter;
  assign y_sh  = y_r >>> iter;
  assign z_neg = z_r[WIDTH-1];
  assign x_rot = z_neg ? (x_r + y_sh)   : (x_r - y_sh);
  assign y_rot = z_neg ? (y_r - x_sh)   : (y_r + x_sh);
  assign z_rot = z_neg ? (z_r + atan_i) : (z_r - atan_i);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = ROTATE;
      ROTATE:  if (last_iter) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iter  <= '0;
      x_r   <= '0;
      y_r   <= '0;
      z_r   <= '0;
      x_out <= '0;
      y_out <= '0;
      z_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x_r  <= x_ld;
            y_r  <= y_ld;
            z_r  <= z_ld;
            iter <= '0;
          end
        end
        ROTATE: begin
          x_r <= x_rot;
          y_r <= y_rot;
          z_r <= z_rot;
          if (last_iter) begin
            // Final step goes straight to the result registers, which then
            // stay untouched until the next operation completes.
            iter  <= '0;
            x_out <= x_rot;
            y_out <= y_rot;
            z_out <= z_rot;
          end else begin
            iter <= iter + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_seq.sv
module tb_cordic_seq;

  localparam int W   = 32;
  localparam int N   = 31;
  localparam int TOL = 64;

  localparam logic [31:0] X0   = 32'h26DD3B6A;  // 0x40000000 / CORDIC gain
  localparam logic [31:0] ONE  = 32'h40000000;
  localparam logic [31:0] K45  = 32'h2D413CCD;  // 0x40000000 * cos(45 deg)
  localparam logic [31:0] NK45 = 32'hD2BEC333;  // -K45

  logic                clk = 1'b0;
  logic                rst_n;
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] x_in, y_in, z_in;
  logic                out_valid;
  logic                out_ready;
  logic signed [W-1:0] x_out, y_out, z_out;
  logic                busy;

  typedef struct {
    int          id;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] z;
  } exp_t;

  exp_t sb[$];
  int   lat_q[$];
  int   acc_log[$];
  int   cyc     = 0;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   op_id   = 0;

  cordic_seq #(.WIDTH(W), .ITERATIONS(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .y_in      (y_in),
    .z_in      (z_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x_out     (x_out),
    .y_out     (y_out),
    .z_out     (z_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", nm, got, exp);
    end
  endtask

  task automatic chk_tol(input string nm, input logic [31:0] got, input logic [31:0] exp);
    int d;
    d = int'(signed'(got - exp));
    n_tests++;
    if (d > TOL || d < -TOL) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h +/- %0d", nm, got, exp, TOL);
    end
  endtask

  task automatic fail_now(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s", nm);
  endtask

  function automatic int last_acc();
    if (acc_log.size() == 0) return -1;
    return acc_log[acc_log.size()-1];
  endfunction

  // Monitor: logs accepts, checks latency on out_valid rise, and checks
  // results against the scoreboard on each output handshake.
  initial begin : monitor
    logic prev_ov;
    exp_t e;
    int   a;
    prev_ov = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        lat_q.delete();
        prev_ov = 1'b0;
      end else begin
        if (in_valid && in_ready) begin
          acc_log.push_back(cyc + 1);
          lat_q.push_back(cyc + 1);
        end
        if (out_valid && !prev_ov) begin
          if (lat_q.size() == 0) fail_now("latency: out_valid with no operand outstanding");
          else begin
            a = lat_q.pop_front();
            // The accepting edge counts as the first of the N edges.
            chk("latency edges", 32'(cyc - a + 1), 32'(N));
          end
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) fail_now("scoreboard: unexpected result handshake");
          else begin
            e = sb.pop_front();
            chk_tol($sformatf("op%0d x_out", e.id), x_out, e.x);
            chk_tol($sformatf("op%0d y_out", e.id), y_out, e.y);
            chk_tol($sformatf("op%0d z_out", e.id), z_out, e.z);
          end
        end
        prev_ov = out_valid;
      end
    end
  end

  task automatic issue(input logic [31:0] xi, input logic [31:0] yi, input logic [31:0] zi,
                       input logic [31:0] ex, input logic [31:0] ey, input logic [31:0] ez,
                       input bit keep);
    exp_t e;
    int   n;
    x_in = xi; y_in = yi; z_in = zi;
    in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 200);
    if (!in_ready) begin
      fail_now("accept timeout");
      in_valid = 1'b0;
      return;
    end
    op_id++;
    e.id = op_id; e.x = ex; e.y = ey; e.z = ez;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0 || busy) fail_now("result timeout");
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int rel;
    int n;
    int changes;
    int m;
    logic [31:0] hx, hy, hz;

    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    x_in = '0; y_in = '0; z_in = '0;
    #1 rst_n = 1'b0;
    #1;
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset busy",      32'(busy),      32'd0);
    chk("reset x_out",     x_out,          32'd0);
    chk("reset y_out",     y_out,          32'd0);
    chk("reset z_out",     z_out,          32'd0);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("in_ready after reset", 32'(in_ready), 32'd1);
    rel = cyc;

    // Directed angles: 0, 45, 135 (quadrant 01), -135 (quadrant 10).
    issue(X0, 32'd0, 32'h00000000, ONE,  32'd0, 32'd0, 1'b0);
    chk("first accept edge after reset", 32'(last_acc()), 32'(rel + 1));
    wait_idle();
    issue(X0, 32'd0, 32'h20000000, K45,  K45,   32'd0, 1'b0);
    wait_idle();
    issue(X0, 32'd0, 32'h60000000, NK45, K45,   32'd0, 1'b0);
    wait_idle();
    issue(X0, 32'd0, 32'hA0000000, NK45, NK45,  32'd0, 1'b0);
    wait_idle();

    // Backpressure in DONE with in_valid held high throughout.
    out_ready = 1'b0;
    issue(X0, 32'd0, 32'h20000000, K45, K45, 32'd0, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 100);
    if (!out_valid) fail_now("backpressure: out_valid never rose");
    hx = x_out; hy = y_out; hz = z_out;
    changes = 0;
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
      chk("backpressure out_valid", 32'(out_valid), 32'd1);
      chk("backpressure in_ready",  32'(in_ready),  32'd0);
      if (x_out !== hx || y_out !== hy || z_out !== hz) changes++;
    end
    chk("backpressure output changes", 32'(changes), 32'd0);
    @(posedge clk);
    #1 out_ready = 1'b1;
    repeat (3) issue(X0, 32'd0, 32'h00000000, ONE, 32'd0, 32'd0, 1'b1);
    in_valid = 1'b0;
    m = acc_log.size();
    if (m >= 3) begin
      chk("accept spacing a", 32'(acc_log[m-2] - acc_log[m-3]), 32'(N + 1));
      chk("accept spacing b", 32'(acc_log[m-1] - acc_log[m-2]), 32'(N + 1));
    end else fail_now("accept spacing: too few accepts logged");
    wait_idle();

    // Abort mid-rotation at i=10, then restart right after release.
    issue(X0, 32'd0, 32'h60000000, NK45, K45, 32'd0, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    chk("busy before abort", 32'(busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("abort out_valid", 32'(out_valid), 32'd0);
    chk("abort busy",      32'(busy),      32'd0);
    chk("abort x_out",     x_out,          32'd0);
    chk("abort y_out",     y_out,          32'd0);
    chk("abort z_out",     z_out,          32'd0);
    sb.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    rel = cyc;
    issue(X0, 32'd0, 32'hA0000000, NK45, NK45, 32'd0, 1'b0);
    chk("accept edge after abort release", 32'(last_acc()), 32'(rel + 1));
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
